// File: rtl/mcu_pkg.sv
// ============================================================================
// Module      : mcu_pkg
// Description : Shared MCU types: control FSM state encoding and boot length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcu_pkg;

    localparam int BOOT_LEN_DEFAULT = 256;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSING = 2'd2,
        ST_PAUSED  = 2'd3
    } mcu_state_e;

endpackage

`default_nettype wire

// File: rtl/mcu_boot_copier.sv
// ============================================================================
// Module      : mcu_boot_copier
// Description : Streams boot words into memory and flags the final transfer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_boot_copier
    import mcu_pkg::*;
#(
    parameter int BOOT_LEN = BOOT_LEN_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_active,
    input  logic [15:0] i_srcData,
    input  logic        i_srcValid,
    output logic        o_srcReady,
    output logic [15:0] o_bootAddr,
    output logic [15:0] o_bootData,
    output logic        o_bootWr,
    output logic        o_lastWord
);

    localparam logic [14:0] c_LAST_CNT = 15'(BOOT_LEN - 1);

    logic [14:0] wordCnt_q;
    logic [14:0] wordCnt_d;
    logic        w_xfer;

    assign w_xfer     = i_active & i_srcValid;
    assign o_lastWord = w_xfer & (wordCnt_q == c_LAST_CNT);

    assign o_srcReady = i_active;
    assign o_bootWr   = w_xfer;
    assign o_bootData = i_srcData;
    assign o_bootAddr = {wordCnt_q, 1'b0};

    // Cleared on the final word so a 32768-word image never relies on wrap.
    always_comb begin
        wordCnt_d = wordCnt_q;
        if (o_lastWord) begin
            wordCnt_d = '0;
        end else if (w_xfer) begin
            wordCnt_d = wordCnt_q + 15'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wordCnt_q <= '0;
        end else begin
            wordCnt_q <= wordCnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mcu_state_ctrl.sv
// ============================================================================
// Module      : mcu_state_ctrl
// Description : MCU boot/run/pause sequencer with boot-image copier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_state_ctrl
    import mcu_pkg::*;
#(
    parameter int BOOT_LEN = BOOT_LEN_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [15:0] i_srcData,
    input  logic        i_srcValid,
    output logic        o_srcReady,
    output logic [15:0] o_bootAddr,
    output logic [15:0] o_bootData,
    output logic        o_bootWr,
    output logic        o_bootOwnsBus,
    output logic        o_isBooted,
    input  logic        i_doPause,
    input  logic        i_extPause,
    output logic        o_startPause,
    input  logic        i_nowPaused,
    input  logic        i_resume,
    output logic        o_isPaused
);

    mcu_state_e state_q;
    logic       isBooted_q;
    logic       startPause_q;
    logic       isPaused_q;
    logic       w_lastWord;

    mcu_boot_copier #(
        .BOOT_LEN (BOOT_LEN)
    ) u_copier (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_active   (~isBooted_q),
        .i_srcData  (i_srcData),
        .i_srcValid (i_srcValid),
        .o_srcReady (o_srcReady),
        .o_bootAddr (o_bootAddr),
        .o_bootData (o_bootData),
        .o_bootWr   (o_bootWr),
        .o_lastWord (w_lastWord)
    );

    // isBooted_q is high exactly outside BOOT, so it doubles as the bus-ownership select.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= ST_BOOT;
            isBooted_q   <= 1'b0;
            startPause_q <= 1'b0;
            isPaused_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    if (w_lastWord) begin
                        state_q    <= ST_RUN;
                        isBooted_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_doPause | i_extPause) begin
                        state_q      <= ST_PAUSING;
                        startPause_q <= 1'b1;
                    end
                end
                ST_PAUSING: begin
                    if (i_nowPaused) begin
                        state_q    <= ST_PAUSED;
                        isPaused_q <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (i_resume) begin
                        state_q      <= ST_RUN;
                        startPause_q <= 1'b0;
                        isPaused_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_BOOT;
                    isBooted_q   <= 1'b0;
                    startPause_q <= 1'b0;
                    isPaused_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_bootOwnsBus = ~isBooted_q;
    assign o_isBooted    = isBooted_q;
    assign o_startPause  = startPause_q;
    assign o_isPaused    = isPaused_q;

endmodule

`default_nettype wire

// File: doc/mcu_state_ctrl.md
MCU_STATE_CTRL -- requirements
Module: mcu_state_ctrl

Interface
REQ-001 Parameter BOOT_LEN, default 256, number of 16-bit words copied into memory at boot (legal range 1..32768).
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rstn  input  1  reset, asynchronous, active-low.
REQ-004 i_srcData  input  16  boot image word from external source.
REQ-005 i_srcValid  input  1  i_srcData holds a valid word.
REQ-006 o_srcReady  output  1  block accepts a word this cycle.
REQ-007 o_bootAddr  output  16  memory byte address for boot write ({wordCnt,1'b0}).
REQ-008 o_bootData  output  16  memory write data during boot.
REQ-009 o_bootWr  output  1  memory write strobe during boot.
REQ-010 o_bootOwnsBus  output  1  top level routes bootAddr/bootData/bootWr to memory instead of the core.
REQ-011 o_isBooted  output  1  boot complete; feeds the core's i_isBooted.
REQ-012 i_doPause  input  1  core requests a pause (PSE in execute).
REQ-013 i_extPause  input  1  external/debug pause request, level.
REQ-014 o_startPause  output  1  feeds the core's i_startPause.
REQ-015 i_nowPaused  input  1  core reports pipeline drained and paused.
REQ-016 i_resume  input  1  single-cycle pulse releasing a pause.
REQ-017 o_isPaused  output  1  MCU is in PAUSED state.

Function
REQ-018 FSM states SHALL be BOOT, RUN, PAUSING, PAUSED, held in a registered state variable.
REQ-019 BOOT: o_srcReady=1, o_bootOwnsBus=1; a transfer occurs when i_srcValid & o_srcReady.
REQ-020 On a transfer, o_bootWr=1 and o_bootData=i_srcData in the same cycle (combinational), o_bootAddr={wordCnt,1'b0}; wordCnt (15 bits) increments on that edge.
REQ-021 On no transfer, o_bootWr=0 and wordCnt holds; idle cycles of any length are legal.
REQ-022 A transfer with wordCnt==BOOT_LEN-1 SHALL move the FSM to RUN on that edge; no further words are accepted (o_srcReady=0 from the next cycle).
REQ-023 o_isBooted SHALL be 1 exactly when the state is not BOOT (registered, so it rises the cycle after the last write).
REQ-024 BOOT_LEN=32768 SHALL complete without counter wrap affecting the final address (last address 0xFFFE).
REQ-025 RUN: if i_doPause | i_extPause, go to PAUSING; o_startPause SHALL be 1 in PAUSING and PAUSED, 0 otherwise.
REQ-026 PAUSING: when i_nowPaused=1, go to PAUSED; pause requests are ignored (already pausing).
REQ-027 PAUSED: o_isPaused=1; i_resume=1 returns to RUN, with o_startPause low the following cycle.
REQ-028 i_resume in any state other than PAUSED SHALL be ignored, including PAUSING (the pause still completes).
REQ-029 Pause requests during BOOT SHALL be ignored; a still-high i_extPause is honoured on the first RUN cycle.
REQ-030 If i_resume and a pause request coincide in PAUSED, go to RUN; the request is re-evaluated next cycle (level i_extPause re-pauses).
REQ-031 In RUN, PAUSING and PAUSED, o_bootOwnsBus=0, o_bootWr=0 and o_srcReady=0.

Reset
REQ-032 Reset asserted SHALL force state=BOOT and wordCnt=0 asynchronously, giving outputs o_isBooted=0, o_startPause=0, o_isPaused=0, o_bootWr=0, o_bootOwnsBus=1 and o_srcReady=1 once i_rstn is released.
REQ-033 Reset mid-boot or mid-pause SHALL discard progress; boot restarts at address 0x0000.

Structure
REQ-034 The FSM state encoding and the BOOT_LEN default SHALL live in the shared MCU package.
REQ-035 The word counter and its terminal-count compare SHALL be one sub-module, mcu_boot_copier; the FSM stays in the top module.

Verification
REQ-036 BOOT_LEN=4, words 0x1111,0x2222,0x3333,0x4444 streamed back-to-back -> writes to 0x0000/0x0002/0x0004/0x0006, o_isBooted rises the cycle after the 4th write.
REQ-037 BOOT_LEN=4, i_srcValid toggled 1/0 -> identical writes with no skips or duplicates, o_srcReady=0 after the 4th word.
REQ-038 After boot, pulse i_doPause; assert i_nowPaused 3 cycles later -> o_startPause=1 from the next cycle, o_isPaused=1 the cycle after i_nowPaused, i_resume -> RUN with both outputs low.
REQ-039 i_extPause held high during boot -> no pause in BOOT; PAUSING entered on the first RUN cycle.
REQ-040 i_resume pulsed in PAUSING -> ignored, PAUSED still reached.
REQ-041 Reset after 2 of 4 boot words -> o_isBooted=0, and the next accepted word is written to 0x0000.
